// File: rtl/packet_dispatch_rr.sv
// packet_dispatch_rr: spreads whole AXI-Stream packets from one source across
// IF_COUNT_UP_TX outputs in round-robin order, skipping outputs whose en_mask
// bit is clear. The chosen output is locked from the first beat to tlast.
// Each output has a 32-bit counter of completed packets.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   s_axis_*            single packet source (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*            IF_COUNT_UP_TX outputs; payload broadcast, tvalid one-hot or zero
//   en_mask             per-output eligibility for new packets
//   sel                 currently locked output index
//   busy                high while a packet is in flight
//   pkt_count           completed packets per output, 32 bits each, wrapping

// Per-output lane: gates tvalid onto this output and counts its packets.
module packet_dispatch_rr_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit,       // this lane is the locked output during SEND
  input  logic        s_tvalid,
  input  logic        done,      // tlast beat handshaken this cycle
  output logic        m_tvalid,
  output logic [31:0] count
);
  assign m_tvalid = hit & s_tvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             count <= '0;
    else if (hit && done) count <= count + 32'd1;
  end
endmodule

module packet_dispatch_rr #(
  parameter int IF_COUNT_UP_TX = 3,
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH/8,
  parameter int USER_WIDTH     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                s_axis_tkeep,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic [USER_WIDTH-1:0]                s_axis_tuser,
  output logic [IF_COUNT_UP_TX*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [IF_COUNT_UP_TX*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [IF_COUNT_UP_TX-1:0]            m_axis_tvalid,
  input  logic [IF_COUNT_UP_TX-1:0]            m_axis_tready,
  output logic [IF_COUNT_UP_TX-1:0]            m_axis_tlast,
  output logic [IF_COUNT_UP_TX*USER_WIDTH-1:0] m_axis_tuser,
  input  logic [IF_COUNT_UP_TX-1:0]            en_mask,
  output logic [1:0]                           sel,
  output logic                                 busy,
  output logic [IF_COUNT_UP_TX*32-1:0]         pkt_count
);
  localparam int SEL_WIDTH = 2;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t               state, state_nx;
  logic [SEL_WIDTH-1:0] sel_nx, rr_ptr, rr_ptr_nx;
  logic [SEL_WIDTH-1:0] pick;
  logic                 pick_vld;
  logic                 sel_ok, cur_rdy, done;

  // Payload is broadcast; only tvalid steers the packet.
  assign m_axis_tdata = {IF_COUNT_UP_TX{s_axis_tdata}};
  assign m_axis_tkeep = {IF_COUNT_UP_TX{s_axis_tkeep}};
  assign m_axis_tlast = {IF_COUNT_UP_TX{s_axis_tlast}};
  assign m_axis_tuser = {IF_COUNT_UP_TX{s_axis_tuser}};

  // An out-of-range sel cannot be produced, but guard the index anyway.
  assign sel_ok        = (int'(sel) < IF_COUNT_UP_TX);
  assign cur_rdy       = sel_ok ? m_axis_tready[sel] : 1'b0;
  assign busy          = (state == SEND);
  assign s_axis_tready = busy & cur_rdy;
  assign done          = s_axis_tvalid & s_axis_tready & s_axis_tlast;

  // Round-robin search starting at rr_ptr; an out-of-range pointer restarts at 0.
  always_comb begin
    int base;
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    base     = (int'(rr_ptr) < IF_COUNT_UP_TX) ? int'(rr_ptr) : 0;
    for (int i = 0; i < IF_COUNT_UP_TX; i++) begin
      idx = base + i;
      if (idx >= IF_COUNT_UP_TX) idx = idx - IF_COUNT_UP_TX;
      if (!pick_vld && en_mask[idx]) begin
        pick     = SEL_WIDTH'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    rr_ptr_nx = rr_ptr;
    case (state)
      IDLE: begin
        // Ready on the outputs is deliberately not part of the choice.
        if (s_axis_tvalid && pick_vld) begin
          sel_nx   = pick;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (done) begin
          state_nx  = IDLE;
          rr_ptr_nx = (int'(sel) >= IF_COUNT_UP_TX-1) ? '0 : sel + SEL_WIDTH'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      sel    <= sel_nx;
      rr_ptr <= rr_ptr_nx;
    end
  end

  for (genvar g = 0; g < IF_COUNT_UP_TX; g++) begin : g_lane
    packet_dispatch_rr_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .hit      (busy && sel == SEL_WIDTH'(g)),
      .s_tvalid (s_axis_tvalid),
      .done     (done),
      .m_tvalid (m_axis_tvalid[g]),
      .count    (pkt_count[g*32 +: 32])
    );
  end
endmodule

// File: tb/tb_packet_dispatch_rr.sv
module tb_packet_dispatch_rr;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int KW = DW/8;
  localparam int UW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_tdata;
  logic [KW-1:0]   s_tkeep;
  logic            s_tvalid, s_tready, s_tlast;
  logic [UW-1:0]   s_tuser;
  logic [N*DW-1:0] m_tdata;
  logic [N*KW-1:0] m_tkeep;
  logic [N-1:0]    m_tvalid, m_tready, m_tlast;
  logic [N*UW-1:0] m_tuser;
  logic [N-1:0]    en_mask;
  logic [1:0]      sel;
  logic            busy;
  logic [N*32-1:0] pkt_count;

  int checks = 0;
  int failures = 0;

  packet_dispatch_rr #(.IF_COUNT_UP_TX(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .en_mask(en_mask), .sel(sel), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string nm, input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
    chk(nm, 192'(pkt_count), 192'({c2, c1, c0}));
  endtask

  // One IDLE bubble, then nb beats on output ex with all outputs ready.
  task automatic send_pkt(input logic [2:0] en, input int nb, input int ex, input logic [63:0] base);
    en_mask  = en;
    m_tready = 3'b111;
    s_tvalid = 1'b1;
    s_tdata  = base;
    s_tlast  = (nb == 1);
    #1;
    chk("idle_busy",   192'(busy), 192'(0));
    chk("idle_tvalid", 192'(m_tvalid), 192'(0));
    chk("idle_tready", 192'(s_tready), 192'(0));
    step();
    for (int b = 0; b < nb; b++) begin
      s_tdata = base + 64'(b);
      s_tlast = (b == nb-1);
      #1;
      chk("send_sel",    192'(sel), 192'(ex));
      chk("send_tvalid", 192'(m_tvalid), 192'(3'b001 << ex));
      chk("send_tready", 192'(s_tready), 192'(1));
      chk("send_tdata",  192'(m_tdata), {3{base + 64'(b)}});
      chk("send_tlast",  192'(m_tlast), 192'({3{b == nb-1}}));
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  typedef struct {
    logic [2:0] en;
    int         nb;
    int         ex;
  } pkt_t;

  pkt_t tbl[11];

  initial begin
    // round robin over all three, then 0/2 only, then a single-beat packet
    tbl[0]  = '{3'b111, 4, 0};
    tbl[1]  = '{3'b111, 4, 1};
    tbl[2]  = '{3'b111, 4, 2};
    tbl[3]  = '{3'b111, 4, 0};
    tbl[4]  = '{3'b111, 4, 1};
    tbl[5]  = '{3'b111, 4, 2};
    tbl[6]  = '{3'b101, 4, 0};
    tbl[7]  = '{3'b101, 4, 2};
    tbl[8]  = '{3'b101, 4, 0};
    tbl[9]  = '{3'b101, 4, 2};
    tbl[10] = '{3'b111, 1, 0};

    rst = 1'b0; s_tdata = '0; s_tkeep = '1; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tuser = '0; m_tready = 3'b111; en_mask = 3'b111;
    #12;
    chk("rst_sel",    192'(sel), 192'(0));
    chk("rst_busy",   192'(busy), 192'(0));
    chk("rst_tvalid", 192'(m_tvalid), 192'(0));
    chk("rst_tready", 192'(s_tready), 192'(0));
    chk_counts("rst_count", 0, 0, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      send_pkt(tbl[i].en, tbl[i].nb, tbl[i].ex, 64'h1000 * 64'(i + 1));
      if (i == 5) chk_counts("rr_count", 2, 2, 2);
    end
    chk_counts("tbl_count", 5, 2, 4);

    // Backpressure on output 1 mid-packet
    en_mask = 3'b111; m_tready = 3'b111;
    s_tvalid = 1'b1; s_tdata = 64'hB0; s_tlast = 1'b0;
    step();
    #1 chk("bp_sel", 192'(sel), 192'(1));
    step();
    s_tdata = 64'hB1; m_tready = 3'b101;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_tready", 192'(s_tready), 192'(0));
      chk("bp_tvalid", 192'(m_tvalid), 192'(3'b010));
      chk("bp_tdata",  192'(m_tdata), {3{64'hB1}});
      step();
    end
    m_tready = 3'b111;
    #1 chk("bp_resume", 192'(s_tready), 192'(1));
    step();
    s_tdata = 64'hB2; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk_counts("bp_count", 5, 3, 4);

    // Disable the locked output mid-packet: packet stays on output 2
    en_mask = 3'b111; s_tvalid = 1'b1; s_tdata = 64'hC0;
    step();
    step();
    en_mask = 3'b011; s_tdata = 64'hC1;
    #1 chk("drop_tvalid", 192'(m_tvalid), 192'(3'b100));
    step();
    s_tdata = 64'hC2; s_tlast = 1'b1;
    #1 chk("drop_tvalid_last", 192'(m_tvalid), 192'(3'b100));
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk_counts("drop_count", 5, 3, 5);
    send_pkt(3'b011, 2, 0, 64'hD0);
    send_pkt(3'b011, 1, 1, 64'hD8);
    send_pkt(3'b011, 1, 0, 64'hDC);  // pointer at 2, disabled -> wraps to 0
    chk_counts("skip_count", 7, 4, 5);

    // No output enabled: input stalls
    en_mask = 3'b000; s_tvalid = 1'b1; s_tdata = 64'hE0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("stall_busy",   192'(busy), 192'(0));
      chk("stall_tready", 192'(s_tready), 192'(0));
      chk("stall_tvalid", 192'(m_tvalid), 192'(0));
      step();
    end
    s_tvalid = 1'b0;
    send_pkt(3'b010, 2, 1, 64'hE0);
    chk_counts("stall_count", 7, 5, 5);

    // Asynchronous reset mid-packet
    en_mask = 3'b111; s_tvalid = 1'b1; s_tdata = 64'hF0;
    step();
    #1 chk("pre_rst_sel", 192'(sel), 192'(2));
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_tvalid", 192'(m_tvalid), 192'(0));
    chk("arst_busy",   192'(busy), 192'(0));
    chk("arst_tready", 192'(s_tready), 192'(0));
    chk_counts("arst_count", 0, 0, 0);
    s_tvalid = 1'b0;
    #1 rst = 1'b1;
    step();
    send_pkt(3'b111, 2, 0, 64'hF8);
    chk_counts("post_rst_count", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
